key_event_detector: RTL and testbench
=====================================

KEY_EVENT_DETECTOR -- requirements
Module: key_event_detector

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_MHZ, default 100, the clock frequency in MHz.
REQ-002 The module SHALL have parameter LONG_PRESS_US, default 500000, the hold time in microseconds that classifies a long press.
REQ-003 The module SHALL have parameter DOUBLE_CLICK_US, default 250000, the post-release window in microseconds for a second press.
REQ-004 The module SHALL have port clk_i, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-005 The module SHALL have port rst_n_i, input, 1 bit, the asynchronous active-low reset.
REQ-006 The module SHALL have port key_pressed_stb_i, input, 1 bit, the one-cycle debounced press strobe from the debouncer.
REQ-007 The module SHALL have port key_i, input, 1 bit, the synchronous key level (1 = held), the same signal that feeds the debouncer.
REQ-008 The module SHALL have port single_click_stb_o, output, 1 bit, a one-cycle pulse for a single click.
REQ-009 The module SHALL have port double_click_stb_o, output, 1 bit, a one-cycle pulse for a double click.
REQ-010 The module SHALL have port long_press_stb_o, output, 1 bit, a one-cycle pulse for a long press.
REQ-011 The module SHALL have port busy_o, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-012 The module SHALL compute LONG_CYCLES = LONG_PRESS_US*CLK_FREQ_MHZ and DC_CYCLES = DOUBLE_CLICK_US*CLK_FREQ_MHZ; elaboration SHALL fail if either value is < 2.
REQ-013 The module SHALL have one timer, unsigned, width $clog2(max(LONG_CYCLES,DC_CYCLES))+1, cleared on every state change and saturating, never wrapping.
REQ-014 The FSM SHALL have exactly the states IDLE, PRESS1, WAIT2 and HOLD.
REQ-015 In IDLE, key_pressed_stb_i = 1 SHALL move the FSM to PRESS1; key_i alone SHALL NOT change state.
REQ-016 In PRESS1, if key_i = 0 the FSM SHALL move to WAIT2; otherwise the timer SHALL increment.
REQ-017 In PRESS1 with key_i = 1, when the timer reaches LONG_CYCLES-1 the FSM SHALL pulse long_press_stb_o and move to HOLD, so the pulse is registered LONG_CYCLES cycles after the edge that sampled the strobe.
REQ-018 In WAIT2, key_pressed_stb_i = 1 SHALL pulse double_click_stb_o on the next edge and move the FSM to HOLD.
REQ-019 In WAIT2, when the timer reaches DC_CYCLES-1 with no strobe, the FSM SHALL pulse single_click_stb_o and move to IDLE.
REQ-020 In WAIT2, if the strobe and the timeout occur in the same cycle, the strobe SHALL win: double click only, no single click.
REQ-021 In HOLD, all strobes SHALL be ignored, and key_i = 0 SHALL move the FSM to IDLE with no pulse.
REQ-022 At most one of the three strobe outputs SHALL be high in any cycle, and each pulse SHALL last exactly one cycle.
REQ-023 A key_pressed_stb_i received in PRESS1 SHALL be ignored.
REQ-024 All outputs SHALL be registered; busy_o SHALL be 0 only in IDLE.

Reset
REQ-025 While rst_n_i = 0, the FSM SHALL be held in IDLE, the timer at 0 and all outputs at 0, independent of the clock.
REQ-026 Asserting reset mid-sequence SHALL abort the sequence with no pulse emitted, including after reset is released.
REQ-027 The first edge after reset release SHALL be able to accept a strobe.

Structure
REQ-028 Package key_event_pkg SHALL hold the state enum type (IDLE, PRESS1, WAIT2, HOLD) and a us_to_cycles function used to derive LONG_CYCLES and DC_CYCLES.
REQ-029 The block SHALL have no sub-module: one FSM, one timer and the output registers.

Verification (CLK_FREQ_MHZ=1, LONG_PRESS_US=20, DOUBLE_CLICK_US=10)
REQ-030 Strobe at edge 0, key_i = 1 for 5 cycles then 0 -> exactly one single_click_stb_o, 10 cycles after the release edge; no other pulse.
REQ-031 Strobe at edge 0, key_i held for 30 cycles -> long_press_stb_o at edge 20; no pulse on release; busy_o falls after release.
REQ-032 Press for 3 cycles, release, second strobe 4 cycles after release -> one double_click_stb_o and no single_click_stb_o.
REQ-033 Second strobe exactly in the WAIT2 timeout cycle -> double_click_stb_o only.
REQ-034 rst_n_i pulsed low during WAIT2 -> all outputs 0, busy_o = 0, and no pulse follows.
REQ-035 Strobes injected in PRESS1 and HOLD -> ignored; event count matches the reference model across 1000 random press/release sequences.

Source files
------------

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and helpers for the key event detector.
//   state_e       - FSM state encoding (IDLE, PRESS1, WAIT2, HOLD)
//   us_to_cycles  - converts a duration in microseconds to clock cycles
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS1 = 2'd1,
    WAIT2  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  function automatic int unsigned us_to_cycles(input int unsigned us,
                                               input int unsigned clk_mhz);
    return us * clk_mhz;
  endfunction

endpackage

// File: rtl/key_event_detector.sv
// key_event_detector: classifies debounced key activity into single click,
// double click and long press events.
//
// Ports
//   clk_i              in   clock, rising edge
//   rst_n_i            in   asynchronous active-low reset
//   key_pressed_stb_i  in   one-cycle debounced press strobe
//   key_i              in   synchronous key level (1 = held)
//   single_click_stb_o out  one-cycle pulse, single click
//   double_click_stb_o out  one-cycle pulse, double click
//   long_press_stb_o   out  one-cycle pulse, long press
//   busy_o             out  high whenever the FSM is not in IDLE
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a press strobe
// PRESS1 | first press held; timing towards a long press
// WAIT2  | first press released; timing the window for a second press
// HOLD   | event already reported; waiting for the key to be released
module key_event_detector
  import key_event_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ    = 100,
  parameter int unsigned LONG_PRESS_US   = 500000,
  parameter int unsigned DOUBLE_CLICK_US = 250000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_pressed_stb_i,
  input  logic key_i,
  output logic single_click_stb_o,
  output logic double_click_stb_o,
  output logic long_press_stb_o,
  output logic busy_o
);

  localparam int unsigned LONG_CYCLES = us_to_cycles(LONG_PRESS_US, CLK_FREQ_MHZ);
  localparam int unsigned DC_CYCLES   = us_to_cycles(DOUBLE_CLICK_US, CLK_FREQ_MHZ);
  localparam int unsigned MAX_CYCLES  = (LONG_CYCLES > DC_CYCLES) ? LONG_CYCLES : DC_CYCLES;
  localparam int          TW          = $clog2(MAX_CYCLES) + 1;

  localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DC_TC   = TW'(DC_CYCLES - 1);

  if (LONG_CYCLES < 2 || DC_CYCLES < 2) begin : g_bad_timing
    $error("key_event_detector: LONG_CYCLES and DC_CYCLES must both be >= 2");
  end

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   timer_inc;
  logic            single_d, double_d, long_d;

  // Saturating increment: the timer never wraps back to zero.
  assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_pressed_stb_i) state_d = PRESS1;
      end
      PRESS1: begin
        // Release takes priority; press strobes are ignored here.
        if (!key_i) begin
          state_d = WAIT2;
        end else if (timer_q == LONG_TC) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT2: begin
        // A strobe in the timeout cycle still counts as a double click.
        if (key_pressed_stb_i) begin
          double_d = 1'b1;
          state_d  = HOLD;
        end else if (timer_q == DC_TC) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      HOLD: begin
        if (!key_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q            <= IDLE;
      timer_q            <= '0;
      single_click_stb_o <= 1'b0;
      double_click_stb_o <= 1'b0;
      long_press_stb_o   <= 1'b0;
      busy_o             <= 1'b0;
    end else begin
      state_q            <= state_d;
      timer_q            <= timer_d;
      single_click_stb_o <= single_d;
      double_click_stb_o <= double_d;
      long_press_stb_o   <= long_d;
      // Registered from the next state so busy_o tracks state_q exactly.
      busy_o             <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_detector.sv
// tb_key_event_detector: directed per-cycle vectors for the main scenarios,
// hand-written async reset sequences, and random press/release sequences
// checked against an event-level expectation.
module tb_key_event_detector;

  localparam int unsigned LONG = 20;
  localparam int unsigned DC   = 10;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic key_pressed_stb_i = 1'b0;
  logic key_i = 1'b0;
  logic single_click_stb_o, double_click_stb_o, long_press_stb_o, busy_o;

  key_event_detector #(
    .CLK_FREQ_MHZ   (1),
    .LONG_PRESS_US  (LONG),
    .DOUBLE_CLICK_US(DC)
  ) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .key_pressed_stb_i (key_pressed_stb_i),
    .key_i             (key_i),
    .single_click_stb_o(single_click_stb_o),
    .double_click_stb_o(double_click_stb_o),
    .long_press_stb_o  (long_press_stb_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // {single, double, long, busy}
  typedef struct {
    int         n;
    logic       rst_n;
    logic       stb;
    logic       key;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  int   n_single = 0, n_double = 0, n_long = 0, n_multi = 0;

  always @(negedge clk_i) begin
    if (single_click_stb_o) n_single++;
    if (double_click_stb_o) n_double++;
    if (long_press_stb_o)   n_long++;
    if ({1'b0, single_click_stb_o} + {1'b0, double_click_stb_o} + {1'b0, long_press_stb_o} > 2'd1)
      n_multi++;
  end

  function automatic logic [3:0] outs();
    return {single_click_stb_o, double_click_stb_o, long_press_stb_o, busy_o};
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b (single,double,long,busy)", nm, act, exp);
    end
  endtask

  task automatic add(input int n, input logic r, input logic s, input logic k,
                     input logic [3:0] e);
    vec_t v;
    v.n = n; v.rst_n = r; v.stb = s; v.key = k; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic s, input logic k);
    key_pressed_stb_i = s;
    key_i             = k;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int sa, da, la;
    int es, ed, el;
    int h, g, h2;
    bit two;

    // Reset held low from time 0
    @(posedge clk_i); #1;
    chk("reset_state", outs(), 4'b0000);
    @(posedge clk_i); #1;
    chk("reset_state_2", outs(), 4'b0000);

    // Release, idle; key alone must not start a sequence
    add(2, 1, 0, 0, 4'b0000);
    add(3, 1, 0, 1, 4'b0000);
    add(1, 1, 0, 0, 4'b0000);

    // Single click: press 5 cycles (strobe in PRESS1 ignored), timeout 10 after release
    add(1, 1, 1, 1, 4'b0001);
    add(1, 1, 0, 1, 4'b0001);
    add(1, 1, 1, 1, 4'b0001);
    add(2, 1, 0, 1, 4'b0001);
    add(1, 1, 0, 0, 4'b0001);
    add(9, 1, 0, 0, 4'b0001);
    add(1, 1, 0, 0, 4'b1000);
    add(3, 1, 0, 0, 4'b0000);

    // Long press: held 30 cycles, pulse at edge 20, strobe in HOLD ignored
    add(1,  1, 1, 1, 4'b0001);
    add(19, 1, 0, 1, 4'b0001);
    add(1,  1, 0, 1, 4'b0011);
    add(4,  1, 0, 1, 4'b0001);
    add(1,  1, 1, 1, 4'b0001);
    add(4,  1, 0, 1, 4'b0001);
    add(1,  1, 0, 0, 4'b0000);
    add(12, 1, 0, 0, 4'b0000);

    // Double click: press 3, release, second strobe 4 cycles after release
    add(1,  1, 1, 1, 4'b0001);
    add(2,  1, 0, 1, 4'b0001);
    add(1,  1, 0, 0, 4'b0001);
    add(3,  1, 0, 0, 4'b0001);
    add(1,  1, 1, 1, 4'b0101);
    add(2,  1, 0, 1, 4'b0001);
    add(1,  1, 0, 0, 4'b0000);
    add(12, 1, 0, 0, 4'b0000);

    // Second strobe exactly in the timeout cycle: double only
    add(1,  1, 1, 1, 4'b0001);
    add(1,  1, 0, 0, 4'b0001);
    add(9,  1, 0, 0, 4'b0001);
    add(1,  1, 1, 1, 4'b0101);
    add(1,  1, 0, 0, 4'b0000);
    add(12, 1, 0, 0, 4'b0000);

    // Reset during WAIT2: no pulse afterwards
    add(1,  1, 1, 1, 4'b0001);
    add(1,  1, 0, 0, 4'b0001);
    add(3,  1, 0, 0, 4'b0001);
    add(2,  0, 0, 0, 4'b0000);
    add(12, 1, 0, 0, 4'b0000);

    // Strobe accepted on the first edge after reset release
    add(2,  0, 0, 0, 4'b0000);
    add(1,  1, 1, 1, 4'b0001);
    add(1,  1, 0, 0, 4'b0001);
    add(9,  1, 0, 0, 4'b0001);
    add(1,  1, 0, 0, 4'b1000);
    add(2,  1, 0, 0, 4'b0000);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        rst_n_i = vecs[i].rst_n;
        cyc(vecs[i].stb, vecs[i].key);
        chk($sformatf("vec[%0d].cyc%0d", i, c), outs(), vecs[i].exp);
      end
    end

    // Async reset in HOLD, with no clock edge in between
    cyc(1, 1);
    for (int i = 0; i < 22; i++) cyc(0, 1);
    chk("hold_busy", outs(), 4'b0001);
    #2 rst_n_i = 1'b0;
    #1 chk("async_rst_hold", outs(), 4'b0000);
    @(posedge clk_i); #1;
    chk("rst_held_hold", outs(), 4'b0000);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 1);
    chk("after_rst_key_held", outs(), 4'b0000);
    for (int i = 0; i < 12; i++) cyc(0, 0);
    chk("after_rst_idle", outs(), 4'b0000);

    // Async reset in PRESS1
    cyc(1, 1);
    cyc(0, 1);
    #2 rst_n_i = 1'b0;
    #1 chk("async_rst_press1", outs(), 4'b0000);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    sa = n_single; da = n_double; la = n_long;
    for (int i = 0; i < 25; i++) cyc(0, 0);
    chk("no_pulse_after_rst",
        {(n_single != sa), (n_double != da), (n_long != la), busy_o}, 4'b0000);

    // Random press/release sequences with event-level expectation
    for (int s = 0; s < 1000; s++) begin
      sa = n_single; da = n_double; la = n_long;
      es = 0; ed = 0; el = 0;
      h   = int'($urandom_range(1, 25));
      two = 1'($urandom_range(0, 1));
      g   = int'($urandom_range(1, 14));
      h2  = int'($urandom_range(1, 6));

      cyc(1, 1);
      for (int i = 1; i < h; i++) cyc(1'($urandom_range(0, 3) == 0), 1);
      cyc(0, 0);
      if (h >= int'(LONG) + 1) begin
        el = 1;
      end else if (two && g <= int'(DC)) begin
        for (int i = 1; i < g; i++) cyc(0, 0);
        cyc(1, 1);
        for (int i = 1; i < h2; i++) cyc(1'($urandom_range(0, 2) == 0), 1);
        cyc(0, 0);
        ed = 1;
      end else begin
        es = 1;
      end
      for (int i = 0; i < 13; i++) cyc(0, 0);

      checks++;
      if ((n_single - sa) != es || (n_double - da) != ed || (n_long - la) != el || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL rand_seq%0d h=%0d two=%0d g=%0d actual s/d/l/busy=%0d/%0d/%0d/%b required=%0d/%0d/%0d/0",
                 s, h, two, g, n_single - sa, n_double - da, n_long - la, busy_o, es, ed, el);
      end
    end

    chk("one_hot_strobes", {3'b000, (n_multi != 0)}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
